// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I-subset control unit: a Moore FSM that sequences the datapath,
// with memory ready stalls, the extended branch set and an illegal-instruction trap.
module mc_control_unit #(
  parameter bit HANDSHAKE  = 1'b1,
  parameter bit BRANCH_EXT = 1'b1,
  parameter bit TRAP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [2:0]  imm_src,
  output logic        illegal,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R, S_EXEC_I,
    S_ALU_WB, S_BRANCH, S_JAL, S_EXEC_JALR, S_JALR_PC, S_LINK_WB, S_LUI, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  state_e     state_q, state_d, dec_next, illegal_next;
  logic       illegal_q, illegal_d;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3, alu_dec;
  logic       alu_ok, br_ok, br_taken, ready;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign ready        = HANDSHAKE ? mem_ready : 1'b1;
  assign illegal_next = TRAP_EN ? S_TRAP : S_FETCH;
  assign state_o      = state_q;
  assign illegal      = illegal_q;

  // funct7 only matters for R-type; I-type shares the mapping minus sub
  always_comb begin
    alu_dec = ALU_ADD;
    alu_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_REG && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      default: alu_ok  = 1'b0;
    endcase
    if (opcode == OP_REG && funct7 != 7'b0000000 &&
        !(funct3 == 3'b000 && funct7 == 7'b0100000))
      alu_ok = 1'b0;
  end

  always_comb begin
    br_ok    = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  begin br_ok = 1'b1;       br_taken = zero;  end
      3'b001:  begin br_ok = BRANCH_EXT; br_taken = !zero; end
      3'b100:  begin br_ok = BRANCH_EXT; br_taken = lt;    end
      3'b101:  begin br_ok = BRANCH_EXT; br_taken = !lt;   end
      default: ;
    endcase
  end

  always_comb begin
    dec_next = illegal_next;
    case (opcode)
      OP_LOAD, OP_STORE: dec_next = S_MEM_ADR;
      OP_REG:            dec_next = alu_ok ? S_EXEC_R : illegal_next;
      OP_IMM:            dec_next = alu_ok ? S_EXEC_I : illegal_next;
      OP_BRANCH:         dec_next = br_ok ? S_BRANCH : illegal_next;
      OP_JAL:            dec_next = S_JAL;
      OP_JALR:           dec_next = S_EXEC_JALR;
      OP_LUI:            dec_next = S_LUI;
      default:           ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (ready) state_d = S_DECODE;
      S_DECODE:    state_d = dec_next;
      S_MEM_ADR:   state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (ready) state_d = S_MEM_WB;
      S_MEM_WR:    if (ready) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    state_d = S_ALU_WB;
      S_JAL,
      S_JALR_PC:   state_d = S_LINK_WB;
      S_EXEC_JALR: state_d = S_JALR_PC;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset overrides everything combinationally so an in-flight access is dropped at once
  always_comb begin
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    imm_src    = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b100 : 3'b010;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEM_RD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = alu_dec;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_dec;
      end
      S_ALU_WB, S_LINK_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        pc_write  = br_taken;
      end
      S_JAL, S_JALR_PC: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_EXEC_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        imm_src    = 3'b011;
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      imm_src    = 3'b000;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: three parameter variants share one stimulus stream and
// are checked every cycle against an instruction-path model, plus literal spot checks.
module tb_mc_control_unit;

  // Instance 0: all features; 1: BRANCH_EXT=0; 2: HANDSHAKE=0, TRAP_EN=0
  localparam bit [2:0] HS_K = 3'b011;
  localparam bit [2:0] BE_K = 3'b101;
  localparam bit [2:0] TE_K = 3'b011;

  localparam int FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5;
  localparam int EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, JAL = 10, EXEC_JALR = 11;
  localparam int JALR_PC = 12, LINK_WB = 13, LUI = 14, TRAP = 15;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_JALR = 6;
  localparam int C_LUI = 7, C_BAD = 8;

  typedef struct packed {
    int st;
    int pos;
    int cls;
    bit ill;
  } mstep_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        zero = 1'b0;
  logic        lt = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] instr = 32'h0;

  wire [2:0]      adr_src_w, mem_read_w, mem_write_w, ir_write_w, reg_write_w, pc_write_w;
  wire [2:0]      illegal_w;
  wire [2:0][1:0] result_src_w, alu_src_a_w, alu_src_b_w;
  wire [2:0][2:0] alu_op_w, imm_src_w;
  wire [2:0][3:0] state_w;

  int     checks = 0;
  int     errors = 0;
  mstep_t m_step [3];
  bit     m_valid [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_control_unit #(.HANDSHAKE(HS_K[g]), .BRANCH_EXT(BE_K[g]), .TRAP_EN(TE_K[g])) u_dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .mem_ready(mem_ready),
      .adr_src(adr_src_w[g]), .mem_read(mem_read_w[g]), .mem_write(mem_write_w[g]),
      .ir_write(ir_write_w[g]), .reg_write(reg_write_w[g]), .pc_write(pc_write_w[g]),
      .result_src(result_src_w[g]), .alu_src_a(alu_src_a_w[g]), .alu_src_b(alu_src_b_w[g]),
      .alu_op(alu_op_w[g]), .imm_src(imm_src_w[g]), .illegal(illegal_w[g]),
      .state_o(state_w[g])
    );
  end

  function automatic int classify(input logic [31:0] ins, input bit be);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    if (op == 7'h03) return C_LW;
    if (op == 7'h23) return C_SW;
    if (op == 7'h6F) return C_JAL;
    if (op == 7'h67) return C_JALR;
    if (op == 7'h37) return C_LUI;
    if (op == 7'h63) return (f3 == 3'd0 || (be && f3 inside {3'd1, 3'd4, 3'd5})) ? C_BR : C_BAD;
    if (op == 7'h13) return (f3 inside {3'd0, 3'd7, 3'd6, 3'd2, 3'd4}) ? C_I : C_BAD;
    if (op == 7'h33) begin
      if (f7 == 7'h00 && f3 inside {3'd0, 3'd7, 3'd6, 3'd2, 3'd4}) return C_R;
      if (f7 == 7'h20 && f3 == 3'd0) return C_R;
    end
    return C_BAD;
  endfunction

  // States visited after DECODE, per instruction class; -1 ends the path
  function automatic int after_decode(input int cls, input bit te, input int pos);
    int p [4];
    p = '{-1, -1, -1, -1};
    case (cls)
      C_LW:    p = '{MEM_ADR, MEM_RD, MEM_WB, -1};
      C_SW:    p = '{MEM_ADR, MEM_WR, -1, -1};
      C_R:     p = '{EXEC_R, ALU_WB, -1, -1};
      C_I:     p = '{EXEC_I, ALU_WB, -1, -1};
      C_BR:    p = '{BRANCH, -1, -1, -1};
      C_JAL:   p = '{JAL, LINK_WB, -1, -1};
      C_JALR:  p = '{EXEC_JALR, JALR_PC, LINK_WB, -1};
      C_LUI:   p = '{LUI, -1, -1, -1};
      default: if (te) p[0] = TRAP;
    endcase
    if (pos > 3) return -1;
    return p[pos];
  endfunction

  function automatic mstep_t model_next(input mstep_t cur, input bit r, input bit rdy,
                                        input bit be, input bit te, input logic [31:0] ins);
    mstep_t n = cur;
    int nxt;
    if (r) begin
      n.st = FETCH; n.pos = 0; n.cls = C_BAD; n.ill = 1'b0;
      return n;
    end
    if (cur.st == TRAP) return n;
    if ((cur.st == FETCH || cur.st == MEM_RD || cur.st == MEM_WR) && !rdy) return n;
    if (cur.st == FETCH) begin
      n.st = DECODE;
      return n;
    end
    if (cur.st == DECODE) begin
      n.cls = classify(ins, be);
      n.pos = 0;
    end
    nxt   = after_decode(n.cls, te, n.pos);
    n.pos = n.pos + 1;
    n.st  = (nxt < 0) ? FETCH : nxt;
    if (n.st == TRAP) n.ill = 1'b1;
    return n;
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] ins);
    case (ins[14:12])
      3'd0:    return (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd2:    return 3'd4;
      3'd4:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic taken(input logic [31:0] ins, input logic z, input logic l);
    case (ins[14:12])
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      default: return 1'b0;
    endcase
  endfunction

  // {adr_src, mem_read, mem_write, ir_write, reg_write, pc_write, result_src, a, b, alu_op, imm_src}
  function automatic logic [17:0] exp_out(input int st, input logic [31:0] ins, input logic z,
                                          input logic l, input logic rdy, input logic r);
    logic ad = 0, mr = 0, mw = 0, iw = 0, rw = 0, pw = 0;
    logic [1:0] rs = 0, a = 0, b = 0;
    logic [2:0] op = 0, imm = 0;
    case (st)
      FETCH:     begin mr = 1; b = 2; rs = 2; iw = rdy; pw = rdy; end
      DECODE:    begin a = 1; b = 1; imm = (ins[6:0] == 7'h6F) ? 3'd4 : 3'd2; end
      MEM_ADR:   begin a = 2; b = 1; imm = (ins[6:0] == 7'h23) ? 3'd1 : 3'd0; end
      MEM_RD:    begin ad = 1; mr = 1; end
      MEM_WB:    begin rs = 1; rw = 1; end
      MEM_WR:    begin ad = 1; mw = 1; end
      EXEC_R:    begin a = 2; op = alu_of(ins); end
      EXEC_I:    begin a = 2; b = 1; op = alu_of(ins); end
      ALU_WB, LINK_WB: rw = 1;
      BRANCH:    begin a = 2; op = 1; pw = taken(ins, z, l); end
      JAL, JALR_PC: begin pw = 1; a = 1; b = 2; end
      EXEC_JALR: begin a = 2; b = 1; end
      LUI:       begin imm = 3; rs = 3; rw = 1; end
      default:   ;
    endcase
    if (r) return 18'h0;
    return {ad, mr, mw, iw, rw, pw, rs, a, b, op, imm};
  endfunction

  function automatic logic [17:0] dut_vec(input int k);
    return {adr_src_w[k], mem_read_w[k], mem_write_w[k], ir_write_w[k], reg_write_w[k],
            pc_write_w[k], result_src_w[k], alu_src_a_w[k], alu_src_b_w[k], alu_op_w[k],
            imm_src_w[k]};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      m_step[k]  <= model_next(m_step[k], rst, HS_K[k] ? mem_ready : 1'b1, BE_K[k], TE_K[k], instr);
      m_valid[k] <= m_valid[k] | rst;
    end
  end

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      if (m_valid[k]) begin
        checks++;
        if (state_w[k] !== m_step[k].st[3:0]) begin
          errors++;
          $display("[TB] FAIL model_state[%0d] actual=%0d expected=%0d", k, state_w[k], m_step[k].st);
        end
        checks++;
        if (dut_vec(k) !== exp_out(m_step[k].st, instr, zero, lt, HS_K[k] ? mem_ready : 1'b1, rst)) begin
          errors++;
          $display("[TB] FAIL model_outputs[%0d] state=%0d actual=%05h expected=%05h", k, m_step[k].st,
                   dut_vec(k), exp_out(m_step[k].st, instr, zero, lt, HS_K[k] ? mem_ready : 1'b1, rst));
        end
        checks++;
        if (illegal_w[k] !== m_step[k].ill) begin
          errors++;
          $display("[TB] FAIL model_illegal[%0d] actual=%0b expected=%0b", k, illegal_w[k], m_step[k].ill);
        end
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic rdy, input logic z, input logic l);
    @(negedge clk);
    rst = r; mem_ready = rdy; zero = z; lt = l;
    #3;
  endtask

  task automatic startVector(input logic [31:0] ins);
    @(negedge clk);
    instr = ins; rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0;
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic runVector(input logic [31:0] ins, input logic z, input logic l, input int n);
    startVector(ins);
    for (int c = 1; c <= n; c++) applyStimulus(1'b0, 1'b1, z, l);
  endtask

  initial begin
    int pulses;
    int seq [8];

    // add x3,x1,x2
    startVector(32'h002081B3);
    checkOutput("reset_mem_read", mem_read_w[0], 0);
    seq = '{FETCH, DECODE, EXEC_R, ALU_WB, FETCH, 0, 0, 0};
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("add_state", state_w[0], seq[c-1]);
      pulses += int'(reg_write_w[0]);
      if (c == 3) checkOutput("add_alu_op", alu_op_w[0], 0);
      if (c == 4) checkOutput("add_reg_write_c4", reg_write_w[0], 1);
    end
    checkOutput("add_reg_write_pulses", pulses, 1);

    // lw with three wait cycles in MEM_RD
    startVector(32'h0000A183);
    seq = '{FETCH, DECODE, MEM_ADR, MEM_RD, MEM_RD, MEM_RD, MEM_RD, MEM_WB};
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1'b0, !(c >= 4 && c <= 6), 1'b0, 1'b0);
      checkOutput("lw_state", state_w[0], (c == 9) ? FETCH : seq[c-1]);
      if (c >= 4 && c <= 7) checkOutput("lw_adr_src", adr_src_w[0], 1);
      if (c == 8) checkOutput("lw_result_src", result_src_w[0], 1);
    end

    // bne, not taken / taken, and trapped when the extension is off
    startVector(32'h00209463);
    for (int c = 1; c <= 3; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bne_state", state_w[0], BRANCH);
    checkOutput("bne_taken_pc_write", pc_write_w[0], 1);
    checkOutput("bne_noext_state", state_w[1], TRAP);
    checkOutput("bne_noext_illegal", illegal_w[1], 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    startVector(32'h00209463);
    for (int c = 1; c <= 3; c++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bne_zero_pc_write", pc_write_w[0], 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // beq taken on the no-extension instance
    startVector(32'h00208463);
    for (int c = 1; c <= 3; c++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("beq_noext_pc_write", pc_write_w[1], 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // jal
    startVector(32'h008000EF);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (c == 2) checkOutput("jal_imm_src", imm_src_w[0], 4);
      if (c == 3) checkOutput("jal_state", state_w[0], JAL);
      if (c == 3) checkOutput("jal_pc_write", pc_write_w[0], 1);
      if (c == 4) checkOutput("jal_link_state", state_w[0], LINK_WB);
      if (c == 4) checkOutput("jal_link_reg_write", reg_write_w[0], 1);
    end

    // unknown opcode: sticky trap, NOP when traps are disabled
    startVector(32'h0000007F);
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (c == 3) checkOutput("bad_notrap_state", state_w[2], FETCH);
      if (c == 3) checkOutput("bad_notrap_illegal", illegal_w[2], 0);
      if (c >= 3) checkOutput("trap_state", state_w[0], TRAP);
      if (c >= 3) checkOutput("trap_illegal", illegal_w[0], 1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("trap_cleared_state", state_w[0], FETCH);
    checkOutput("trap_cleared_illegal", illegal_w[0], 0);

    // sw aborted by reset while waiting in MEM_WR
    startVector(32'h0020A023);
    for (int c = 1; c <= 3; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_state", state_w[0], MEM_WR);
    checkOutput("sw_mem_write", mem_write_w[0], 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_rst_mem_write", mem_write_w[0], 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("sw_rst_state", state_w[0], FETCH);
    checkOutput("sw_rst_reg_write", reg_write_w[0], 0);

    // addi with a two-cycle FETCH stall
    startVector(32'h00510093);
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(1'b0, !(c <= 2), 1'b0, 1'b0);
      if (c == 1) checkOutput("stall_ir_write", ir_write_w[0], 0);
      if (c == 1) checkOutput("stall_pc_write", pc_write_w[0], 0);
      if (c == 3) checkOutput("fetch_ir_write", ir_write_w[0], 1);
      if (c == 4) checkOutput("stall_decode_state", state_w[0], DECODE);
    end

    // remaining classes, checked through the model plus a few literals
    runVector(32'h402081B3, 1'b0, 1'b0, 5);
    runVector(32'h00514093, 1'b0, 1'b0, 5);
    startVector(32'h123450B7);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (c == 3) checkOutput("lui_state", state_w[0], LUI);
      if (c == 3) checkOutput("lui_result_src", result_src_w[0], 3);
    end
    startVector(32'h000100E7);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (c == 4) checkOutput("jalr_pc_state", state_w[0], JALR_PC);
    end
    runVector(32'h0020C463, 1'b0, 1'b1, 4);
    runVector(32'h0020D463, 1'b0, 1'b1, 4);
    runVector(32'h002091B3, 1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multi-cycle RISC-V (RV32I subset) control unit. It sits beside the multi-cycle datapath (PC, OldPC, IR, register file, ALU, ALUOut, MDR, unified memory) and sequences it through a Moore state machine. It adds a memory ready handshake with stall, the extended branch set (beq/bne/blt/bge), decoded ALU control, LUI, and an illegal-instruction trap state.

## Interface
- HANDSHAKE, 1: 1 = honour `mem_ready`; 0 = `mem_ready` internally tied to 1.
- BRANCH_EXT, 1: 1 = beq/bne/blt/bge legal; 0 = only beq legal, other funct3 values illegal.
- TRAP_EN, 1: 1 = an illegal instruction enters TRAP; 0 = an illegal instruction returns to FETCH as a NOP.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: IR contents.
- `zero` in 1: ALU result == 0.
- `lt` in 1: signed rs1 < rs2, from the datapath comparator.
- `mem_ready` in 1: memory completes the current access this cycle.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`, `pc_write` out 1 each.
- `result_src` out 2: result bus select. 00 = ALUOut, 01 = MDR, 10 = ALU result, 11 = immediate.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op` out 3: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 U, 100 J.
- `illegal` out 1: sticky trap flag.
- `state_o` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, EXEC_JALR, JALR_PC, LINK_WB, LUI, TRAP.
- Outputs are decoded from the registered state only. Exception: `pc_write` in BRANCH also depends on `zero` and `lt`. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, a=00, b=10, add, `result_src`=10. `ir_write`=`pc_write`=`mem_ready`. Holds while `!mem_ready`, otherwise goes to DECODE.
- DECODE: a=01, b=01, add, so ALUOut = OldPC+imm. `imm_src`=100 if opcode is JAL, else 010. Next state by opcode:
  - lw/sw → MEM_ADR; R → EXEC_R; I-ALU → EXEC_I.
  - branch → BRANCH; JAL → JAL; JALR → EXEC_JALR; LUI → LUI.
  - anything else → TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0).
- ALU decode:
  - R: funct3 000 with funct7 0000000 → add; funct3 000 with funct7 0100000 → sub; 111 → and; 110 → or; 010 → slt; 100 → xor.
  - I: same mapping without sub.
  - Any other funct3/funct7 combination is illegal and is detected in DECODE.
- MEM_ADR: a=10, b=01, add, `imm_src`=000 (lw) or 001 (sw). Next is MEM_RD or MEM_WR.
- MEM_RD: `adr_src`=1, `mem_read`=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB: `result_src`=01, `reg_write`=1. Next is FETCH.
- MEM_WR: `adr_src`=1, `mem_write`=1. Holds until `mem_ready`, then FETCH.
- EXEC_R: a=10, b=00, decoded op. EXEC_I: a=10, b=01, `imm_src`=000, decoded op. Both go to ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`=1. Next is FETCH.
- BRANCH:
  - a=10, b=00, sub, `result_src`=00.
  - `pc_write` = taken: beq=`zero`, bne=`!zero`, blt=`lt`, bge=`!lt`.
  - Next is FETCH.
- JAL / JALR_PC: `result_src`=00, `pc_write`=1, a=01, b=10, add, so ALUOut = OldPC+4. Next is LINK_WB.
- EXEC_JALR: a=10, b=01, `imm_src`=000, add. Next is JALR_PC. Clearing the target LSB is the datapath's job.
- LINK_WB: `result_src`=00, `reg_write`=1. Next is FETCH.
- LUI: `imm_src`=011, `result_src`=11, `reg_write`=1. Next is FETCH.
- TRAP: all enables 0; `illegal` is set and stays set until `rst`; the FSM stays in TRAP.

## Timing
- Reset: `rst` is sampled on the rising edge.
  - Next state is FETCH and `illegal`=0.
  - While `rst`=1, all enables and `mem_read` are forced to 0 combinationally, and every mux select is 0.
- Reset mid-operation (for example, in MEM_WR) aborts the access. `mem_write` drops in the same cycle `rst` rises, and no partial writeback occurs.
- Latency in cycles with `mem_ready`=1: R/I 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui 3.
- Each wait cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. During a wait, outputs are held and no write enable other than `mem_write` is asserted.
- `ir_write` and `pc_write` in FETCH are asserted only in the cycle `mem_ready`=1, so a stall cannot double-increment PC.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB; `alu_op`=000; one `reg_write` pulse in cycle 4.
- `lw` (0x0000A183) with `mem_ready` low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles, `adr_src`=1 throughout, then MEM_WB with `result_src`=01. Total 8 cycles.
- `bne` (0x00209463):
  - with `zero`=0 → `pc_write`=1 in BRANCH;
  - with `zero`=1 → `pc_write`=0;
  - with BRANCH_EXT=0 the same word → TRAP.
- `jal` (0x008000EF) → JAL with `pc_write`=1, then LINK_WB with `reg_write`=1. `imm_src`=100 in DECODE.
- Opcode 0x7F with TRAP_EN=1 → TRAP after DECODE, `illegal`=1 held for 10 cycles, and `rst` clears it to FETCH. With TRAP_EN=0 → back to FETCH, no enables asserted.
- `sw` (0x0020A023) with `rst` asserted during MEM_WR → `mem_write` falls in the same cycle, and the next state is FETCH.
